uart_rx_multibyte: RTL and testbench

//  Parametrised oversampling UART receiver for the bus serial bridge.
//  - Assembles NUM_BYTES byte segments, sent LSB byte first, into one DATA_WIDTH word.
//  - Each segment: start/separator bit (0), 8 data bits LSB-first, STOP_BITS stop bits (1).
//  - Adds over the fixed 16-bit receiver: start-bit glitch rejection, stop/separator framing

---
 rtl/uart_rx_multibyte.sv | 144 ++++++++++++++
 tb/tb_uart_rx_multibyte.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_multibyte.sv
// Oversampling UART receiver that assembles NUM_BYTES framed byte segments
// (LSB byte first) into one word, committing it only when every segment framed cleanly.
module uart_rx_multibyte #(
  parameter int NUM_BYTES  = 2,
  parameter int DATA_WIDTH = 8*NUM_BYTES,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clken,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ready,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CW  = $clog2(OVERSAMPLE);
  localparam int BIW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, SEP, DONE, ERR} state_t;

  state_t                state;
  logic                  rx_s1, rx_s;
  logic [CW-1:0]         cnt;
  logic [2:0]            bit_idx;
  logic [1:0]            stop_idx;
  logic [BIW-1:0]        byte_idx;
  logic [DATA_WIDTH-1:0] shift;
  logic                  err_pend;

  logic mid, half, last_stop, last_byte;
  assign mid       = (cnt == CW'(OVERSAMPLE-1));
  assign half      = (cnt == CW'(OVERSAMPLE/2-1));
  assign last_stop = (stop_idx == 2'(STOP_BITS-1));
  assign last_byte = (byte_idx == BIW'(NUM_BYTES-1));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s  <= rx_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      stop_idx  <= '0;
      byte_idx  <= '0;
      shift     <= '0;
      err_pend  <= 1'b0;
      data_out  <= '0;
      ready     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      ready     <= 1'b0;
      frame_err <= 1'b0;
      if (clken) begin
        case (state)
          IDLE: if (!rx_s) begin
            state    <= START;
            cnt      <= '0;
            byte_idx <= '0;
          end
          START: if (half) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
          // Bits shift in at the MSB; after the final data bit the first one sits at bit 0.
          DATA: if (mid) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[DATA_WIDTH-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state    <= STOP;
              stop_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
          STOP: if (mid) begin
            cnt <= '0;
            if (!rx_s) begin
              state    <= ERR;
              err_pend <= 1'b1;
            end else if (last_stop) begin
              if (last_byte) begin
                state <= DONE;
              end else begin
                state    <= SEP;
                byte_idx <= byte_idx + 1'b1;
              end
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
          SEP: if (mid) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state    <= ERR;
              err_pend <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
          DONE: begin
            data_out <= shift;
            ready    <= 1'b1;
            state    <= IDLE;
          end
          // Stay here while the line is low so a stuck-low rx cannot retrigger a frame.
          ERR: begin
            if (err_pend) begin
              frame_err <= 1'b1;
              err_pend  <= 1'b0;
            end
            if (rx_s) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_multibyte.sv
// Directed bench for uart_rx_multibyte: a 2-byte/16x/2-stop instance clocked every clk
// and a 1-byte/8x/1-stop instance clocked every 3rd clk.
module tb_uart_rx_multibyte;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clken0 = 1'b1;
  logic        clken1 = 1'b0;
  logic        rx0 = 1'b1;
  logic        rx1 = 1'b1;
  logic [15:0] data_out0;
  logic [7:0]  data_out1;
  logic        ready0, frame_err0, busy0;
  logic        ready1, frame_err1, busy1;

  int pass_n = 0;
  int total_n = 0;
  int rdy0_n = 0, err0_n = 0, both_n = 0, rdy1_n = 0, err1_n = 0;
  int ph = 0;

  uart_rx_multibyte #(.NUM_BYTES(2), .OVERSAMPLE(16), .STOP_BITS(2)) dut0 (
    .clk(clk), .rst(rst), .clken(clken0), .rx(rx0),
    .data_out(data_out0), .ready(ready0), .frame_err(frame_err0), .busy(busy0)
  );

  uart_rx_multibyte #(.NUM_BYTES(1), .OVERSAMPLE(8), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .clken(clken1), .rx(rx1),
    .data_out(data_out1), .ready(ready1), .frame_err(frame_err1), .busy(busy1)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    ph = (ph == 2) ? 0 : ph + 1;
    clken1 = (ph == 0);
  end

  always @(negedge clk) begin
    if (ready0) rdy0_n++;
    if (frame_err0) err0_n++;
    if (ready0 && frame_err0) both_n++;
    if (ready1) rdy1_n++;
    if (frame_err1) err1_n++;
  end

  task automatic idle0(input int n);
    rx0 = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic bit0(input logic b);
    rx0 = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic byte0(input logic [7:0] d, input logic stop2);
    bit0(1'b0);
    for (int i = 0; i < 8; i++) bit0(d[i]);
    bit0(1'b1);
    bit0(stop2);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total_n++; if (data_out0 !== 16'h0) $display("FAIL reset_data got %h want 0000", data_out0); else pass_n++;
    total_n++; if (ready0 !== 1'b0) $display("FAIL reset_ready got %b want 0", ready0); else pass_n++;
    total_n++; if (frame_err0 !== 1'b0) $display("FAIL reset_err got %b want 0", frame_err0); else pass_n++;
    total_n++; if (busy0 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy0); else pass_n++;
  endtask

  task automatic test_frame;
    int r0, e0;
    r0 = rdy0_n; e0 = err0_n;
    byte0(8'h5A, 1'b1);
    byte0(8'hA5, 1'b1);
    idle0(48);
    total_n++; if (data_out0 !== 16'hA55A) $display("FAIL frame_data got %h want a55a", data_out0); else pass_n++;
    total_n++; if (rdy0_n - r0 !== 1) $display("FAIL frame_ready got %0d want 1", rdy0_n - r0); else pass_n++;
    total_n++; if (err0_n - e0 !== 0) $display("FAIL frame_err got %0d want 0", err0_n - e0); else pass_n++;
  endtask

  task automatic test_glitch;
    int r0, e0;
    r0 = rdy0_n; e0 = err0_n;
    rx0 = 1'b0;
    repeat (4) @(negedge clk);
    total_n++; if (busy0 !== 1'b1) $display("FAIL glitch_busy_hi got %b want 1", busy0); else pass_n++;
    idle0(12);
    total_n++; if (busy0 !== 1'b0) $display("FAIL glitch_busy_lo got %b want 0", busy0); else pass_n++;
    idle0(20);
    total_n++; if (rdy0_n - r0 !== 0) $display("FAIL glitch_ready got %0d want 0", rdy0_n - r0); else pass_n++;
    total_n++; if (err0_n - e0 !== 0) $display("FAIL glitch_err got %0d want 0", err0_n - e0); else pass_n++;
  endtask

  task automatic test_stop_err;
    int r0, e0;
    r0 = rdy0_n; e0 = err0_n;
    byte0(8'h34, 1'b0);
    idle0(48);
    total_n++; if (err0_n - e0 !== 1) $display("FAIL stop_err_pulse got %0d want 1", err0_n - e0); else pass_n++;
    total_n++; if (rdy0_n - r0 !== 0) $display("FAIL stop_err_ready got %0d want 0", rdy0_n - r0); else pass_n++;
    total_n++; if (data_out0 !== 16'hA55A) $display("FAIL stop_err_hold got %h want a55a", data_out0); else pass_n++;
    r0 = rdy0_n;
    byte0(8'h34, 1'b1);
    byte0(8'h12, 1'b1);
    idle0(48);
    total_n++; if (rdy0_n - r0 !== 1) $display("FAIL retry_ready got %0d want 1", rdy0_n - r0); else pass_n++;
    total_n++; if (data_out0 !== 16'h1234) $display("FAIL retry_data got %h want 1234", data_out0); else pass_n++;
  endtask

  task automatic test_sep_err;
    int r0, e0;
    r0 = rdy0_n; e0 = err0_n;
    byte0(8'h77, 1'b1);
    idle0(64);
    total_n++; if (err0_n - e0 !== 1) $display("FAIL sep_err_pulse got %0d want 1", err0_n - e0); else pass_n++;
    total_n++; if (rdy0_n - r0 !== 0) $display("FAIL sep_err_ready got %0d want 0", rdy0_n - r0); else pass_n++;
    total_n++; if (busy0 !== 1'b0) $display("FAIL sep_err_idle got %b want 0", busy0); else pass_n++;
  endtask

  task automatic test_mid_reset;
    int r0;
    byte0(8'hEF, 1'b1);
    bit0(1'b0);
    bit0(1'b1);
    bit0(1'b0);
    bit0(1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_n++; if (data_out0 !== 16'h0) $display("FAIL midrst_data got %h want 0000", data_out0); else pass_n++;
    total_n++; if (busy0 !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy0); else pass_n++;
    idle0(32);
    r0 = rdy0_n;
    byte0(8'hEF, 1'b1);
    byte0(8'hBE, 1'b1);
    idle0(48);
    total_n++; if (data_out0 !== 16'hBEEF) $display("FAIL beef_data got %h want beef", data_out0); else pass_n++;
    total_n++; if (rdy0_n - r0 !== 1) $display("FAIL beef_ready got %0d want 1", rdy0_n - r0); else pass_n++;
  endtask

  task automatic test_small;
    int r1, e1;
    logic [9:0] seq;
    r1 = rdy1_n; e1 = err1_n;
    seq = {1'b1, 8'h3C, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx1 = seq[i];
      repeat (24) @(negedge clk);
    end
    rx1 = 1'b1;
    repeat (72) @(negedge clk);
    total_n++; if (data_out1 !== 8'h3C) $display("FAIL small_data got %h want 3c", data_out1); else pass_n++;
    total_n++; if (rdy1_n - r1 !== 1) $display("FAIL small_ready_cycles got %0d want 1", rdy1_n - r1); else pass_n++;
    total_n++; if (err1_n - e1 !== 0) $display("FAIL small_err got %0d want 0", err1_n - e1); else pass_n++;
  endtask

  initial begin
    test_reset;
    test_frame;
    test_glitch;
    test_stop_err;
    test_sep_err;
    test_mid_reset;
    test_small;
    total_n++; if (both_n !== 0) $display("FAIL ready_and_err_together got %0d want 0", both_n); else pass_n++;
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
